// File: rtl/video_obj_store.sv
// video_obj_store: polygon object RAM with matrix R/W port, clip read port, valid map, write-first forwarding and vertex loadback
// Ports: clk, rst (sync, active-high); mat_wr_en/mat_rd_en/mat_addr/mat_wr_data -> mat_rd_data/vld/hit;
//   clip_rd_en/clip_addr -> clip_rd_data/vld/hit; lb_start/lb_addr -> lb_busy/vld/idx/x/y/attr/done; rd_perr.
// Optional VOBJ_PARITY_EN: per-entry even parity, rechecked on every read and loadback fetch; otherwise rd_perr is 0.
module video_obj_store #(
  parameter int ADDR_W = 5,
  parameter int COORD_W = 16,
  parameter int NVERT = 4,
  parameter int ATTR_W = 16,
  localparam int DEPTH = 2**ADDR_W,
  localparam int IDX_W = NVERT > 1 ? $clog2(NVERT) : 1,
  localparam int OBJ_W = 2*COORD_W*NVERT + ATTR_W
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               mat_wr_en,
  input  logic               mat_rd_en,
  input  logic [ADDR_W-1:0]  mat_addr,
  input  logic [OBJ_W-1:0]   mat_wr_data,
  output logic [OBJ_W-1:0]   mat_rd_data,
  output logic               mat_rd_vld,
  output logic               mat_rd_hit,
  input  logic               clip_rd_en,
  input  logic [ADDR_W-1:0]  clip_addr,
  output logic [OBJ_W-1:0]   clip_rd_data,
  output logic               clip_rd_vld,
  output logic               clip_rd_hit,
  input  logic               lb_start,
  input  logic [ADDR_W-1:0]  lb_addr,
  output logic               lb_busy,
  output logic               lb_vld,
  output logic [IDX_W-1:0]   lb_idx,
  output logic [COORD_W-1:0] lb_x,
  output logic [COORD_W-1:0] lb_y,
  output logic [ATTR_W-1:0]  lb_attr,
  output logic               lb_done,
  output logic               rd_perr
);
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  logic [OBJ_W-1:0] ram [DEPTH];
  logic [DEPTH-1:0] valid;
  state_t state;
  logic [ADDR_W-1:0] lb_a;
  logic [OBJ_W-1:0] snap;
  logic [IDX_W-1:0] nidx;
  logic fwd_c, fwd_l, fvalid;
  logic [OBJ_W-1:0] fobj;
  assign fwd_c = mat_wr_en && clip_addr == mat_addr;
  assign fwd_l = mat_wr_en && mat_addr == lb_a;
  assign fobj = fwd_l ? mat_wr_data : ram[lb_a];
  assign fvalid = fwd_l || valid[lb_a];
  assign nidx = lb_idx + 1'b1;
  assign lb_busy = state != IDLE;
  always_ff @(posedge clk)
    if (mat_wr_en) ram[mat_addr] <= mat_wr_data;
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else if (mat_wr_en) valid[mat_addr] <= 1'b1;
  // the matrix port shares one address, so any concurrent write forwards to its own read
  always_ff @(posedge clk)
    if (rst) begin
      mat_rd_data <= '0;
      mat_rd_vld <= 1'b0;
      mat_rd_hit <= 1'b0;
      clip_rd_data <= '0;
      clip_rd_vld <= 1'b0;
      clip_rd_hit <= 1'b0;
    end else begin
      mat_rd_vld <= mat_rd_en;
      clip_rd_vld <= clip_rd_en;
      if (mat_rd_en) begin
        mat_rd_data <= mat_wr_en ? mat_wr_data : valid[mat_addr] ? ram[mat_addr] : '0;
        mat_rd_hit <= mat_wr_en || valid[mat_addr];
      end
      if (clip_rd_en) begin
        clip_rd_data <= fwd_c ? mat_wr_data : valid[clip_addr] ? ram[clip_addr] : '0;
        clip_rd_hit <= fwd_c || valid[clip_addr];
      end
    end
  // FETCH snapshots the whole object so later writes cannot disturb an emission in progress
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      lb_vld <= 1'b0;
      lb_idx <= '0;
      lb_x <= '0;
      lb_y <= '0;
      lb_attr <= '0;
      lb_done <= 1'b0;
    end else
      case (state)
        IDLE: if (lb_start) begin
          state <= FETCH;
          lb_a <= lb_addr;
        end
        FETCH: begin
          snap <= fobj;
          state <= fvalid ? EMIT : DONE;
          lb_vld <= fvalid;
          lb_done <= !fvalid;
          lb_idx <= '0;
          if (fvalid) begin
            lb_x <= fobj[0 +: COORD_W];
            lb_y <= fobj[COORD_W +: COORD_W];
            lb_attr <= fobj[OBJ_W-1 -: ATTR_W];
          end
        end
        EMIT: if (lb_idx == IDX_W'(NVERT-1)) begin
          state <= DONE;
          lb_vld <= 1'b0;
          lb_done <= 1'b1;
        end else begin
          lb_idx <= nidx;
          lb_x <= snap[2*COORD_W*int'(nidx) +: COORD_W];
          lb_y <= snap[2*COORD_W*int'(nidx) + COORD_W +: COORD_W];
        end
        default: begin
          state <= IDLE;
          lb_done <= 1'b0;
        end
      endcase
`ifdef VOBJ_PARITY_EN
  logic [DEPTH-1:0] par;
  logic perr_m, perr_c, perr_f;
  assign perr_m = mat_rd_en && !mat_wr_en && valid[mat_addr] && ((^ram[mat_addr]) != par[mat_addr]);
  assign perr_c = clip_rd_en && !fwd_c && valid[clip_addr] && ((^ram[clip_addr]) != par[clip_addr]);
  assign perr_f = state == FETCH && !fwd_l && valid[lb_a] && ((^ram[lb_a]) != par[lb_a]);
  always_ff @(posedge clk)
    if (mat_wr_en) par[mat_addr] <= ^mat_wr_data;
  always_ff @(posedge clk)
    rd_perr <= rst ? 1'b0 : perr_m || perr_c || perr_f;
`else
  assign rd_perr = 1'b0;
`endif
endmodule
